// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions,
// the decoded bundle type and the field-extraction helper used by decode.
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_BNE   = 6'b000101;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_LUI   = 6'b010101;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    opcode_t        opcode;
    word_t          rs_content;
    word_t          rt_content;
    logic [4:0]     shamt;
    logic [5:0]     alu_control;
    logic [15:0]    immediate;
    reg_idx_t       dest_reg;
    logic           reg_write;
  } bundle_t;

  // Branches and stores are the only opcodes that never write a register.
  function automatic bundle_t decode_instr(input word_t instr, input word_t rs_val,
                                           input word_t rt_val);
    bundle_t b;
    opcode_t op;
    op            = instr[OPC_MSB:OPC_LSB];
    b.opcode      = op;
    b.rs_content  = rs_val;
    b.rt_content  = rt_val;
    b.shamt       = instr[SHAMT_MSB:SHAMT_LSB];
    b.alu_control = (op == OP_RTYPE) ? instr[FUNCT_MSB:FUNCT_LSB] : 6'b000000;
    b.immediate   = instr[IMM_MSB:IMM_LSB];
    b.dest_reg    = (op == OP_RTYPE) ? instr[RD_MSB:RD_LSB] : instr[RT_MSB:RT_LSB];
    b.reg_write   = !((op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW));
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake, writeback and decoded-bundle signals of the decode stage.
// slave is the decode stage itself; master is the surrounding pipeline.
interface decode_stage_if;
  import cpu_pkg::*;

  logic       in_valid;
  logic       in_ready;
  word_t      instruction;
  logic       wb_en;
  reg_idx_t   wb_addr;
  word_t      wb_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  opcode_t    opcode;
  word_t      rs_content;
  word_t      rt_content;
  logic [4:0] shamt;
  logic [5:0] ALU_control;
  logic [15:0] immediate;
  reg_idx_t   dest_reg;
  logic       reg_write;

  modport slave (
    input  in_valid, instruction, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, opcode, rs_content, rt_content, shamt,
           ALU_control, immediate, dest_reg, reg_write
  );

  modport master (
    output in_valid, instruction, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, opcode, rs_content, rt_content, shamt,
           ALU_control, immediate, dest_reg, reg_write
  );

endinterface

// File: rtl/reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear. Register 0 is hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t rd_addr_a,
  output word_t    rd_data_a,
  input  reg_idx_t rd_addr_b,
  output word_t    rd_data_b,
  input  logic     wr_en,
  input  reg_idx_t wr_addr,
  input  word_t    wr_data
);

  word_t regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: single-entry pipeline register between fetch and ALU with
// operand read. Optional macro WB_FORWARD_EN bypasses same-cycle writeback.
module decode_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  logic    valid_q;
  logic    accept;
  bundle_t bundle_q;
  bundle_t bundle_d;
  word_t   rf_a;
  word_t   rf_b;
  word_t   rs_val;
  word_t   rt_val;
  reg_idx_t rs_idx;
  reg_idx_t rt_idx;

  assign rs_idx = bus.instruction[RS_MSB:RS_LSB];
  assign rt_idx = bus.instruction[RT_MSB:RT_LSB];

  // flush wins over accept by closing the input side for that cycle
  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  reg_file u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs_idx),
    .rd_data_a (rf_a),
    .rd_addr_b (rt_idx),
    .rd_data_b (rf_b),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_addr),
    .wr_data   (bus.wb_data)
  );

`ifdef WB_FORWARD_EN
  always_comb begin
    rs_val = rf_a;
    rt_val = rf_b;
    if (bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rs_idx)) rs_val = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rt_idx)) rt_val = bus.wb_data;
  end
`else
  assign rs_val = rf_a;
  assign rt_val = rf_b;
`endif

  assign bundle_d = decode_instr(bus.instruction, rs_val, rt_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      if (bus.flush)          valid_q <= 1'b0;
      else if (accept)        valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;
      if (accept) bundle_q <= bundle_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.opcode      = bundle_q.opcode;
  assign bus.rs_content  = bundle_q.rs_content;
  assign bus.rt_content  = bundle_q.rt_content;
  assign bus.shamt       = bundle_q.shamt;
  assign bus.ALU_control = bundle_q.alu_control;
  assign bus.immediate   = bundle_q.immediate;
  assign bus.dest_reg    = bundle_q.dest_reg;
  assign bus.reg_write   = bundle_q.reg_write;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream instruction word is valid.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 instruction  input  32  raw instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct, [15:0] immediate.
REQ-007 wb_en  input  1  writeback strobe into the register file.
REQ-008 wb_addr  input  5  writeback register index.
REQ-009 wb_data  input  32  writeback data.
REQ-010 flush  input  1  discard the held decoded instruction.
REQ-011 out_valid  output  1  decoded bundle is valid for the ALU.
REQ-012 out_ready  input  1  ALU side consumes the bundle.
REQ-013 opcode  output  6  registered opcode to the ALU.
REQ-014 rs_content / rt_content  output  32 each  registered operand values.
REQ-015 shamt  output  5  registered shift amount.
REQ-016 ALU_control  output  6  registered funct when opcode==6'b000000, else 6'b000000.
REQ-017 immediate  output  16  registered instruction[15:0].
REQ-018 dest_reg  output  5  rd for opcode 0, rt otherwise.
REQ-019 reg_write  output  1  0 for opcodes 000100, 000101, 101011; 1 otherwise.

Function
REQ-020 Single-entry pipeline register; in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-021 Accept = in_valid && in_ready; on accept, all bundle outputs SHALL update at the next rising edge and out_valid SHALL become 1 (latency 1 cycle).
REQ-022 Consume = out_valid && out_ready without accept SHALL clear out_valid next edge; simultaneous consume and accept SHALL keep out_valid=1 with the new bundle (full throughput).
REQ-023 While out_valid=1 and out_ready=0, all bundle outputs SHALL hold stable.
REQ-024 flush SHALL clear out_valid next edge and has priority over accept; in_ready is forced to 0 while flush=1.
REQ-025 Operands SHALL be read from the register file at accept time; register 0 SHALL read 0 and writes to register 0 SHALL be ignored.
REQ-026 Register file write SHALL occur at the rising edge when wb_en=1, independent of handshake and flush.
REQ-027 Bundle data fields SHALL be don't-care-free: when out_valid=0 they retain their last values.

Reset
REQ-028 rst_n low SHALL asynchronously clear out_valid, all bundle outputs, and all 32 registers to 0.
REQ-029 Reset mid-handshake SHALL drop the held bundle; first accept is possible on the first edge after rst_n rises.

Configuration
REQ-030 With WB_FORWARD_EN defined, an accept coinciding with wb_en=1 and wb_addr equal to a nonzero rs/rt SHALL capture wb_data for that operand.
REQ-031 Without WB_FORWARD_EN, the same case SHALL capture the pre-write register value.

Structure
REQ-032 Opcode constants (R-type 000000, BEQ 000100, BNE 000101, SW 101011, LUI 010101) and field bit positions SHALL live in shared package cpu_pkg.
REQ-033 The 32x32 register file SHALL be sub-module reg_file (2 async read ports, 1 sync write port, async active-low clear).

Verification
REQ-034 Reset, then write r3=0x0000_00AA via wb, accept instruction 0x0062_2020 (rs=3, rt=2, rd=4, funct 100000) -> next cycle out_valid=1, rs_content=0xAA, rt_content=0, ALU_control=0x20, dest_reg=4, reg_write=1.
REQ-035 Accept LUI 0x5400_DB00 -> opcode=010101, immediate=0xDB00, ALU_control=0, dest_reg=0, reg_write=1.
REQ-036 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; raise out_ready with new instruction -> bundle replaced in one cycle, no bubble.
REQ-037 Same-cycle wb_en=1, wb_addr=3, wb_data=0x1234 and accept reading rs=3 (r3=0xAA) -> rs_content=0x1234 with WB_FORWARD_EN, 0xAA without; write to r0 -> r0 still reads 0.
REQ-038 flush asserted together with in_valid=1 while out_valid=1 -> out_valid=0 next cycle, instruction not accepted; rst_n pulsed mid-stall -> out_valid=0 immediately, registers 0.
